univ_shift_reg_n: RTL and testbench
===================================

Name: univ_shift_reg_n

Overview:
- Parametrised N-bit universal shift register; next generation of the 4-bit hold/shift/load block.
- Adds:
  - rotate and arithmetic-shift modes
  - serial in/out chaining pins
  - a burst engine that performs a programmed number of shifts after a single start pulse, with busy/done handshake
- Used as a datapath building block: serializers, barrel-free multi-bit shifts, LFSR seeding.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of burst shift-count input; max burst = 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-high reset.
- en  input  1  single-step enable; applies mode once per cycle when idle.
- mode  input  3  operation select (encoding below).
- parin  input  WIDTH  parallel load data.
- sin_r  input  1  serial bit entering MSB on right shift.
- sin_l  input  1  serial bit entering LSB on left shift.
- start  input  1  burst request, sampled when idle.
- cnt  input  CNT_W  number of burst steps.
- out  output  WIDTH  register contents.
- sout_r  output  1  = out[0] (bit leaving on next right shift/rotate).
- sout_l  output  1  = out[WIDTH-1] (bit leaving on next left shift/rotate).
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after last burst step.

Behaviour:
- Reset (clr=1, async): out=0, busy=0, done=0, internal count=0, latched mode=000. Held while clr=1; a burst in progress is abandoned, with no done pulse.
- mode encoding:
  - 000 hold
  - 001 SHR: {sin_r, out[W-1:1]}
  - 010 SHL: {out[W-2:0], sin_l}
  - 011 LOAD: parin
  - 100 ROR: {out[0], out[W-1:1]}
  - 101 ROL: {out[W-2:0], out[W-1]}
  - 110 ASR: {out[W-1], out[W-1:1]}
  - 111 reserved = hold.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch mode and cnt.
  - If cnt==0 → DONE with no data change.
  - Else perform step 1 this edge; if cnt==1 go DONE, else go RUN with remaining=cnt-1.
  - start=1 has priority over en.
  - start=0, en=1 → apply mode once; stay IDLE.
  - start=0, en=0 → hold.
- RUN:
  - busy=1.
  - Apply latched mode each edge and decrement remaining; at remaining==1 the step is applied and the FSM goes to DONE.
  - start, en and mode inputs are ignored.
  - sin_r/sin_l are sampled live every step, so they serve as a serializer feed.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start in DONE is ignored.
- busy is registered; it is 1 from the edge after start is accepted until the edge entering DONE. A burst of N>=1 steps gives busy high for N-1 cycles.
- Burst LOAD: every step reloads live parin; a cnt of 1 is the intended use.
- Latency: single step, 1 cycle; burst of N, result valid in the same cycle done=1.
- sout_r and sout_l are combinational from out.

Decomposition:
- Package univ_shift_pkg:
  - mode localparams (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_ASR)
  - FSM state encoding.
- Sub-module shift_step_n: combinational next-value function (mode, cur, sin_r, sin_l, parin → next), WIDTH-parametrised. Reused by both the single-step and burst paths.

Test Plan (WIDTH=8, CNT_W=4):
- Reset: clr=1 at t≠edge → out=00, busy=0, done=0 immediately. Release, then idle with en=0 → out stays 00.
- Load then step: en=1, mode=011, parin=B3 → out=B3.
  - SHR with sin_r=1 → D9.
  - Reload B3, ROL → 67.
  - Reload B3, SHL with sin_l=0 → 66.
- Burst ASR: out=80, start=1, mode=110, cnt=3 → out 80→C0→E0→F0; busy=1 for 2 cycles; done=1 in the cycle out=F0.
- Burst ROR full turn: out=A5, cnt=8 → out=A5 when done=1. start=1 and en=1 with mode=011 asserted mid-burst are ignored.
- cnt=0: start=1 → done=1 next cycle, busy never 1, out unchanged.
- clr mid-burst: during cnt=8 burst, pulse clr after step 3 → out=00, busy=0, no done pulse. Next start begins a clean burst.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// -----------------------------------------------------------------------------
// univ_shift_pkg
// Shared definitions for the universal shift register family. It holds the
// operation-select encodings and the burst engine state encoding.
// Importers: shift_step_n, univ_shift_reg_n.
// -----------------------------------------------------------------------------
package univ_shift_pkg;

  // Operation select. 3'b111 is reserved and behaves as hold.
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  // Burst engine states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step_n.sv
// -----------------------------------------------------------------------------
// shift_step_n
// Purely combinational next-value function for one shift-register step. The
// single-step path and the burst path share this one instance.
// Ports:
//   mode_i  : operation select (univ_shift_pkg MODE_*)
//   cur_i   : current register contents
//   sin_r_i : bit shifted into the MSB on SHR
//   sin_l_i : bit shifted into the LSB on SHL
//   parin_i : parallel load data
//   nxt_o   : register value after applying mode_i once
// -----------------------------------------------------------------------------
module shift_step_n
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic             sin_r_i,
  input  logic             sin_l_i,
  input  logic [WIDTH-1:0] parin_i,
  output logic [WIDTH-1:0] nxt_o
);

  always_comb begin
    nxt_o = cur_i;
    case (mode_i)
      MODE_SHR:  nxt_o = {sin_r_i, cur_i[WIDTH-1:1]};
      MODE_SHL:  nxt_o = {cur_i[WIDTH-2:0], sin_l_i};
      MODE_LOAD: nxt_o = parin_i;
      MODE_ROR:  nxt_o = {cur_i[0], cur_i[WIDTH-1:1]};
      MODE_ROL:  nxt_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
      MODE_ASR:  nxt_o = {cur_i[WIDTH-1], cur_i[WIDTH-1:1]};
      default:   nxt_o = cur_i;   // hold and reserved
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_n.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_n
// Parametrised N-bit universal shift register with hold/shift/rotate/arith
// shift/load modes, serial chaining pins and a burst engine that applies a
// latched mode a programmed number of times after one start pulse.
// Ports:
//   clk    : rising-edge clock
//   clr    : asynchronous active-high reset
//   en     : single-step enable (idle only)
//   mode   : operation select
//   parin  : parallel load data
//   sin_r  : serial input into the MSB on right shift
//   sin_l  : serial input into the LSB on left shift
//   start  : burst request, sampled only in idle
//   cnt    : number of burst steps
//   out    : register contents
//   sout_r : out[0], the bit leaving on the next right shift/rotate
//   sout_l : out[WIDTH-1], the bit leaving on the next left shift/rotate
//   busy   : burst in progress
//   done   : one-cycle pulse after the last burst step
// -----------------------------------------------------------------------------
module univ_shift_reg_n
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] parin,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] out,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q,   out_d;
  logic [CNT_W-1:0]   rem_q,   rem_d;
  logic [2:0]         mode_q,  mode_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic [2:0]         step_mode;
  logic [WIDTH-1:0]   step_nxt;

  // While a burst runs the latched mode drives the step; otherwise the live
  // mode input does (single step, or the first step of a burst).
  assign step_mode = (state_q == ST_RUN) ? mode_q : mode;

  shift_step_n #(.WIDTH(WIDTH)) u_step (
    .mode_i  (step_mode),
    .cur_i   (out_q),
    .sin_r_i (sin_r),
    .sin_l_i (sin_l),
    .parin_i (parin),
    .nxt_o   (step_nxt)
  );

  // Next-state / datapath.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          if (cnt == '0) begin
            // Empty burst: handshake only, data untouched.
            state_d = ST_DONE;
          end else begin
            // Step 1 happens on the accepting edge itself.
            out_d = step_nxt;
            rem_d = cnt - CNT_W'(1);
            state_d = (cnt == CNT_W'(1)) ? ST_DONE : ST_RUN;
          end
        end else if (en) begin
          out_d = step_nxt;
        end
      end
      ST_RUN: begin
        out_d = step_nxt;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // busy/done are registered copies of the decoded next state so they come
  // straight from flops.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out    = out_q;
  assign sout_r = out_q[0];
  assign sout_l = out_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg_n
// Scoreboard bench: the driver advances a behavioural model at each clock edge
// and queues the expected outputs; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg_n;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          en = 1'b0, start = 1'b0, sin_r = 1'b0, sin_l = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [W-1:0]  parin = '0;
  logic [CW-1:0] cnt = '0;
  logic [W-1:0]  out;
  logic          sout_r, sout_l, busy, done;

  univ_shift_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .parin(parin),
    .sin_r(sin_r), .sin_l(sin_l), .start(start), .cnt(cnt),
    .out(out), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] out;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: register value, steps still owed by a burst, and whether
  // the current cycle is the done cycle.
  int m_out   = 0;
  int m_left  = 0;
  bit m_done  = 1'b0;
  int m_bmode = 0;

  function automatic int f_step(int md, int v, int sr, int sl, int p);
    case (md)
      1: return (v >> 1) | (sr << 7);            // shift right, sin_r into MSB
      2: return ((v << 1) & 255) | sl;           // shift left, sin_l into LSB
      3: return p;                               // load
      4: return (v >> 1) | ((v & 1) << 7);       // rotate right
      5: return ((v << 1) & 255) | (v >> 7);     // rotate left
      6: return (v >> 1) | (v & 128);            // divide by 2 keeping sign
      default: return v;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_left = 0; m_done = 1'b0; m_bmode = 0;
  endtask

  task automatic model_edge();
    if (clr) begin
      model_reset();
    end else if (m_done) begin
      m_done = 1'b0;                              // done lasts one cycle; inputs ignored
    end else if (m_left > 0) begin
      m_out = f_step(m_bmode, m_out, int'(sin_r), int'(sin_l), int'(parin));
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (start) begin
      m_bmode = int'(mode);
      if (cnt == 0) begin
        m_done = 1'b1;
      end else begin
        m_out  = f_step(m_bmode, m_out, int'(sin_r), int'(sin_l), int'(parin));
        m_left = int'(cnt) - 1;
        if (m_left == 0) m_done = 1'b1;
      end
    end else if (en) begin
      m_out = f_step(int'(mode), m_out, int'(sin_r), int'(sin_l), int'(parin));
    end
  endtask

  // One clock: advance model at the edge, queue expectation, step off the edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_edge();
    e.out  = 8'(m_out);
    e.busy = (m_left > 0);
    e.done = m_done;
    q.push_back(e);
    #1;
  endtask

  // Async clear between edges, checked immediately, held across one edge.
  task automatic pulse_clr();
    #2 clr = 1'b1;
    model_reset();
    q.delete();
    #1;
    check("clr_out",  out,  32'h0);
    check("clr_busy", busy, 32'h0);
    check("clr_done", done, 32'h0);
    tick();
    clr = 1'b0;
  endtask

  // Monitor: the register presents a new result every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("mon_out",    out,    e.out);
      check("mon_busy",   busy,   e.busy);
      check("mon_done",   done,   e.done);
      check("mon_sout_r", sout_r, e.out[0]);
      check("mon_sout_l", sout_l, e.out[7]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted away from an edge must clear outputs at once.
    #2 clr = 1'b1;
    #1;
    check("rst_out",  out,  32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_done", done, 32'h0);
    tick();
    clr = 1'b0;
    repeat (2) tick();

    // Load and single steps.
    en = 1'b1; mode = 3'b011; parin = 8'hB3; tick();
    check("load", out, 32'hB3);
    mode = 3'b001; sin_r = 1'b1; tick();
    check("shr", out, 32'hD9);
    mode = 3'b011; tick();
    mode = 3'b101; tick();
    check("rol", out, 32'h67);
    mode = 3'b011; tick();
    mode = 3'b010; sin_l = 1'b0; tick();
    check("shl", out, 32'h66);
    mode = 3'b111; tick();
    check("rsvd_hold", out, 32'h66);

    // Burst ASR of 3 from 80.
    mode = 3'b011; parin = 8'h80; tick();
    en = 1'b0; start = 1'b1; mode = 3'b110; cnt = 4'd3; tick();
    start = 1'b0; mode = 3'b000;
    check("asr1", out, 32'hC0);
    check("asr1_busy", busy, 32'h1);
    tick();
    check("asr2", out, 32'hE0);
    tick();
    check("asr3", out, 32'hF0);
    check("asr_done", done, 32'h1);
    check("asr_busy_off", busy, 32'h0);
    tick();

    // Full-turn ROR with noise on start/en/mode during the run.
    en = 1'b1; mode = 3'b011; parin = 8'hA5; tick();
    en = 1'b0; start = 1'b1; mode = 3'b100; cnt = 4'd8; tick();
    start = 1'b1; en = 1'b1; mode = 3'b011; parin = 8'h00;
    repeat (7) tick();
    check("ror_full", out, 32'hA5);
    check("ror_done", done, 32'h1);
    // start still high in the done cycle is ignored.
    en = 1'b0; cnt = 4'd1; tick();
    check("done_ign", out, 32'hA5);
    start = 1'b0; tick();

    // Empty burst.
    start = 1'b1; mode = 3'b001; cnt = 4'd0; tick();
    start = 1'b0;
    check("cnt0_done", done, 32'h1);
    check("cnt0_out", out, 32'hA5);
    tick();

    // Clear mid-burst, then a clean burst.
    start = 1'b1; mode = 3'b100; cnt = 4'd8; tick();
    start = 1'b0; repeat (2) tick();
    pulse_clr();
    repeat (3) tick();
    start = 1'b1; mode = 3'b010; sin_l = 1'b1; cnt = 4'd4; tick();
    start = 1'b0; repeat (3) tick();
    check("post_clr_burst", out, 32'h0F);
    check("post_clr_done", done, 32'h1);
    tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 4) == 0);
      en    = $urandom_range(0, 1);
      mode  = 3'($urandom_range(0, 7));
      cnt   = 4'($urandom_range(0, 15));
      parin = 8'($urandom);
      sin_r = $urandom_range(0, 1);
      sin_l = $urandom_range(0, 1);
      if ($urandom_range(0, 59) == 0) pulse_clr();
      else tick();
    end

    start = 1'b0; en = 1'b0;
    tick();
    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", q.size(), 32'h0);
    if (n_cmp < 1000) begin
      n_bad++;
      $display("FAIL too_few_compares: got %0d expected at least 1000", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
